// File: rtl/modn_counter_cascade_pkg.sv
// -----------------------------------------------------------------------------
// modn_counter_cascade_pkg
//   Shared definitions for the modulo-N counter cascade.
//   - Default geometry (2 digits of packed BCD).
//   - digit_max:          largest legal digit value (MODULO-1).
//   - digit_out_of_range: true when a raw digit value cannot be stored.
//   - clamp_digit:        maps an out-of-range digit onto MODULO-1.
//   - params_legal:       geometry sanity check for integrators.
//   All helpers work on plain int so a single definition serves every
//   WIDTH/MODULO combination; callers cast the result back to WIDTH bits.
// -----------------------------------------------------------------------------
package modn_counter_cascade_pkg;

  localparam int DEFAULT_DIGITS = 2;
  localparam int DEFAULT_MODULO = 10;
  localparam int DEFAULT_WIDTH  = 4;

  // Largest value a single digit may hold.
  function automatic int digit_max(input int modulo);
    return modulo - 1;
  endfunction

  // A raw digit is illegal once it reaches the modulus.
  function automatic bit digit_out_of_range(input int value, input int modulo);
    return value >= modulo;
  endfunction

  // Saturate an illegal digit to the top of the range, so loaded values can
  // never leave the counter in a state the count logic does not expect.
  function automatic int clamp_digit(input int value, input int modulo);
    if (digit_out_of_range(value, modulo)) begin
      return digit_max(modulo);
    end
    return value;
  endfunction

  // True when the digit width can represent every value 0..modulo-1.
  function automatic bit params_legal(input int digits, input int modulo,
                                      input int width);
    return (digits >= 1) && (modulo >= 2) && (width >= 1) && (width <= 31) &&
           (longint'(modulo) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/modn_counter_cascade_digit.sv
// -----------------------------------------------------------------------------
// modn_digit
//   One modulo-MODULO up/down digit of the cascade.
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous reset, active-high (q -> 0)
//     clr     synchronous clear (highest priority)
//     load    synchronous parallel load of the clamped value of d
//     d       raw load value for this digit
//     en_in   count enable (carry/borrow from the digit below)
//     up      1 = increment, 0 = decrement
//     q       registered digit value, always within 0..MODULO-1
//     cy_out  carry (up) or borrow (down) into the next digit; combinational
// -----------------------------------------------------------------------------
module modn_digit
  import modn_counter_cascade_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int MODULO = DEFAULT_MODULO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en_in,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             cy_out
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(digit_max(MODULO));

  logic [WIDTH-1:0] d_clamped;
  logic             at_max;
  logic             at_zero;

  assign d_clamped = WIDTH'(clamp_digit(int'(d), MODULO));
  assign at_max    = (q == MAX);
  assign at_zero   = (q == '0);

  // The digit passes the enable on only when it is itself about to roll
  // over, which is exactly the ripple condition of the next digit.
  assign cy_out = en_in & (up ? at_max : at_zero);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, whatever the evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d_clamped;
    end else if (en_in) begin
      if (up) begin
        q <= at_max ? '0 : q + WIDTH'(1);
      end else begin
        q <= at_zero ? MAX : q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modn_counter_cascade.sv
// -----------------------------------------------------------------------------
// modn_counter_cascade
//   Multi-digit modulo-N up/down counter built from DIGITS cascaded
//   modn_digit instances. MODULO=10, WIDTH=4 yields packed BCD suitable for
//   7-segment display drivers.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous reset, active-high (out -> 0, wrap -> 0)
//     en        count enable
//     up        1 = count up, 0 = count down
//     clr       synchronous clear to zero (priority over load and en)
//     load      synchronous parallel load (priority over en)
//     load_val  load value, digit 0 in [WIDTH-1:0]; digits >= MODULO are
//               stored as MODULO-1
//     out       registered count, digit 0 in [WIDTH-1:0]
//     tc        combinational terminal count: high in the cycle whose next
//               edge wraps the whole counter
//     wrap      registered one-cycle pulse following each wrap edge
// -----------------------------------------------------------------------------
module modn_counter_cascade
  import modn_counter_cascade_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int MODULO = DEFAULT_MODULO,
  parameter int WIDTH  = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_val,
  output logic [DIGITS*WIDTH-1:0] out,
  output logic                    tc,
  output logic                    wrap
);

  // carry[k] is the enable into digit k; carry[DIGITS] is high only when
  // every digit sits at its rollover value with counting enabled.
  logic [DIGITS:0] carry;

  assign carry[0] = en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    modn_digit #(
      .WIDTH  (WIDTH),
      .MODULO (MODULO)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .load   (load),
      .d      (load_val[k*WIDTH +: WIDTH]),
      .en_in  (carry[k]),
      .up     (up),
      .q      (out[k*WIDTH +: WIDTH]),
      .cy_out (carry[k+1])
    );
  end

  // clr and load override counting on the same edge, so they must also
  // suppress the terminal count.
  assign tc = carry[DIGITS] & ~clr & ~load;

  // NOTE: only control/status flops exist here and each gets an explicit
  // reset value; there is no storage array that would need one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_modn_counter_cascade.sv
// -----------------------------------------------------------------------------
// tb_modn_counter_cascade
//   Self-checking bench. The reference model holds the count as one integer
//   in 0..MODULO**DIGITS-1 and steps it with modular arithmetic; it is
//   converted to packed digits only for comparison.
// -----------------------------------------------------------------------------
module tb_modn_counter_cascade;

  localparam int DIGITS = 2;
  localparam int MODULO = 10;
  localparam int WIDTH  = 4;
  localparam int DW     = DIGITS * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          up;
  logic          clr;
  logic          load;
  logic [DW-1:0] load_val;
  logic [DW-1:0] out;
  logic          tc;
  logic          wrap;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // Reference model state.
  int m_val  = 0;
  bit m_wrap = 1'b0;

  modn_counter_cascade #(
    .DIGITS (DIGITS),
    .MODULO (MODULO),
    .WIDTH  (WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int total_count();
    int t = 1;
    for (int i = 0; i < DIGITS; i++) t = t * MODULO;
    return t;
  endfunction

  // Integer value -> packed digits, digit 0 least significant.
  function automatic logic [DW-1:0] to_packed(input int v);
    logic [DW-1:0] p = '0;
    int            r = v;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*WIDTH +: WIDTH] = WIDTH'(r % MODULO);
      r = r / MODULO;
    end
    return p;
  endfunction

  // Raw load word -> integer value after per-digit saturation.
  function automatic int load_value(input logic [DW-1:0] raw);
    int v      = 0;
    int weight = 1;
    int dg;
    for (int i = 0; i < DIGITS; i++) begin
      dg = int'(raw[i*WIDTH +: WIDTH]);
      if (dg > MODULO - 1) dg = MODULO - 1;
      v      = v + dg * weight;
      weight = weight * MODULO;
    end
    return v;
  endfunction

  function automatic bit model_tc();
    return en && !clr && !load &&
           (up ? (m_val == total_count() - 1) : (m_val == 0));
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: steps on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val  = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = model_tc();
      if (clr)       m_val = 0;
      else if (load) m_val = load_value(load_val);
      else if (en)   m_val = up ? (m_val + 1) % total_count()
                                : (m_val + total_count() - 1) % total_count();
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("model_out",  32'(out),  32'(to_packed(m_val)));
      check("model_tc",   32'(tc),   32'(model_tc()));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  // Apply inputs, take one edge, settle 1 time unit after it.
  task automatic cycle(input logic e, input logic u, input logic c,
                       input logic l, input logic [DW-1:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out",  32'(out),  32'h00);
    check("reset_wrap", 32'(wrap), 32'h0);
    started = 1'b1;
    rst = 1'b0;

    // Twelve up-counts from zero.
    repeat (12) cycle(1, 1, 0, 0, '0);
    check("count12", 32'(out), 32'h12);

    // Up wrap from 98.
    cycle(0, 1, 0, 1, 8'h98);
    check("load98", 32'(out), 32'h98);
    cycle(1, 1, 0, 0, '0);
    check("up_to99", 32'(out), 32'h99);
    check("tc_at99", 32'(tc),  32'h1);
    cycle(1, 1, 0, 0, '0);
    check("up_wrap_out",  32'(out),  32'h00);
    check("up_wrap_flag", 32'(wrap), 32'h1);
    cycle(1, 1, 0, 0, '0);
    check("wrap_drops", 32'(wrap), 32'h0);
    check("after_wrap", 32'(out),  32'h01);

    // Down counting and down wrap.
    cycle(0, 0, 0, 1, 8'h10);
    cycle(1, 0, 0, 0, '0);
    check("down_borrow", 32'(out), 32'h09);
    cycle(0, 0, 0, 1, 8'h00);
    check("tc_at00_down", 32'(tc), 32'h0);
    cycle(1, 0, 0, 0, '0);
    check("down_wrap_out",  32'(out),  32'h99);
    check("down_wrap_flag", 32'(wrap), 32'h1);

    // Load clamp.
    cycle(0, 1, 0, 1, 8'hC7);
    check("clamp_c7", 32'(out), 32'h97);
    cycle(0, 1, 0, 1, 8'hFF);
    check("clamp_ff", 32'(out), 32'h99);

    // Priority.
    cycle(0, 1, 0, 1, 8'h45);
    cycle(1, 1, 1, 1, 8'h30);
    check("prio_clr", 32'(out), 32'h00);
    cycle(0, 1, 0, 1, 8'h45);
    cycle(1, 1, 0, 1, 8'h30);
    check("prio_load", 32'(out), 32'h30);

    // Async reset between edges.
    cycle(0, 1, 0, 1, 8'h56);
    cycle(1, 1, 0, 0, '0);
    check("pre_reset", 32'(out), 32'h57);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out",  32'(out),  32'h00);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1, 1, 0, 0, '0);
    check("resume", 32'(out), 32'h01);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 8'h99;
        1:       load_val = 8'h00;
        2:       load_val = 8'h98;
        default: load_val = DW'($urandom);
      endcase
      @(posedge clk);
      #1;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
